// File: rtl/multiple_mask_seq.sv
// Purpose: builds a bitmask of every multiple of SEL below A, plus its population count.
// Latency: k+2 cycles from accepted start to done (k = number of set bits); 1 cycle when SEL==0.
// Backpressure: start is ignored while busy; no queueing. clr aborts at any time.
module multiple_mask_seq #(
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(WIDTH) + 1,
    parameter int SW    = 5,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [AW-1:0]    a_in,
    input  logic [SW-1:0]    sel_in,
    input  logic             incl_zero,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mask_out,
    output logic [CW-1:0]    count_out
);

    // One bit of headroom over the wider operand so acc + SEL cannot wrap
    // before the compare against A or WIDTH fails.
    localparam int ACCW = ((AW > SW) ? AW : SW) + 1;
    localparam logic [ACCW-1:0] WLIM = ACCW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] a_lim;
    logic [ACCW-1:0] sel_step;
    logic            hit;
    logic [WIDTH-1:0] onehot;

    // Current candidate is accepted only while below both the limit and the mask width.
    always_comb begin
        hit    = (acc < a_lim) && (acc < WLIM);
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (acc == ACCW'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

    // Control FSM with registered outputs; clr overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mask_out  <= '0;
            count_out <= '0;
            acc       <= '0;
            a_lim     <= '0;
            sel_step  <= '0;
        end else if (clr) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mask_out  <= '0;
            count_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_lim     <= ACCW'(a_in);
                        sel_step  <= ACCW'(sel_in);
                        mask_out  <= '0;
                        count_out <= '0;
                        busy      <= 1'b1;
                        if (sel_in == '0) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err   <= 1'b0;
                            acc   <= incl_zero ? '0 : ACCW'(sel_in);
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (hit) begin
                        mask_out  <= mask_out | onehot;
                        count_out <= count_out + CW'(1);
                        acc       <= acc + sel_step;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
